fsic_pl_is_axil_slave: RTL and testbench

AXI4-Lite responder for the PL_IS (FPGA-side IO-serdes) configuration window at base + 0x7000. It terminates the transactions the PS/VIP master issues, holds the serdes enable/control registers, and drives the local `txen`/`rxen` enables into the PL io_serdes. It is one register slave only: a single outstanding transaction, independent AW/W acceptance, and a 1-cycle response.

---
 rtl/fsic_pl_is_axil_slave_if.sv | 37 +++
 rtl/fsic_pl_is_axil_slave.sv | 204 ++++++++++++++++++++
 tb/tb_fsic_pl_is_axil_slave.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsic_pl_is_axil_slave_if.sv
// AXI4-Lite bus bundle for the PL_IS configuration slave.
// The master modport is the PS/VIP side, the slave modport is the register block.
interface fsic_pl_is_axil_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/fsic_pl_is_axil_slave.sv
// AXI4-Lite register slave for the PL_IS io-serdes configuration window.
// Holds CTRL (txen/rxen), STATUS, SCRATCH and ID; one transaction in flight.
// Optional feature macro: FSIC_PL_IS_SLVERR_EN -- unmapped offsets answer SLVERR.
module fsic_pl_is_axil_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] ID_VALUE    = 32'h4649_5331,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset_n,
    fsic_pl_is_axil_slave_if.slave        axil,
    input  logic                          tx_busy,
    input  logic                          rx_sync,
    output logic                          txen,
    output logic                          rxen
);

`ifdef FSIC_PL_IS_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RESP = 2'd1,
        ST_RD_DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;

    // Write channel holding registers (AW and W land independently)
    logic        aw_held_q, aw_held_d;
    logic [9:0]  awaddr_q, awaddr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // Architectural registers
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] scratch_q, scratch_d;

    // Response registers, frozen while waiting for the handshake
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] aw_full, ar_full;
    logic        in_idle;
    logic        aw_ready, w_ready, ar_ready;
    logic        aw_hs, w_hs, ar_hs, wr_go;
    logic [9:0]  wr_word;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;
    logic        unused_addr_bits;

    assign aw_full = axil.s_awaddr;
    assign ar_full = axil.s_araddr;

    // Only [11:2] select a register; the rest is decoded upstream or ignored.
    assign unused_addr_bits = ^{aw_full, ar_full};

    // Readies are gated by reset so they drop the moment reset asserts.
    assign in_idle  = (state_q == ST_IDLE) && axi_reset_n;
    assign aw_ready = in_idle && !aw_held_q;
    assign w_ready  = in_idle && !w_held_q;
    assign aw_hs    = axil.s_awvalid && aw_ready;
    assign w_hs     = axil.s_wvalid && w_ready;
    // A write pair completing this cycle beats a pending read.
    assign wr_go    = in_idle && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign ar_ready = in_idle && !wr_go;
    assign ar_hs    = axil.s_arvalid && ar_ready;

    // The write uses held values when present, otherwise the live bus.
    assign wr_word  = aw_held_q ? awaddr_q : aw_full[11:2];
    assign wr_data  = w_held_q ? wdata_q : axil.s_wdata;
    assign wr_strb  = w_held_q ? wstrb_q : axil.s_wstrb;

    assign axil.s_awready = aw_ready;
    assign axil.s_wready  = w_ready;
    assign axil.s_arready = ar_ready;
    assign axil.s_bvalid  = (state_q == ST_WR_RESP);
    assign axil.s_rvalid  = (state_q == ST_RD_DATA);
    assign axil.s_bresp   = bresp_q;
    assign axil.s_rresp   = rresp_q;
    assign axil.s_rdata   = rdata_q;

    assign rxen = ctrl_q[0];
    assign txen = ctrl_q[1];

    // Next-state for the transaction FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_go)      state_d = ST_WR_RESP;
                else if (ar_hs) state_d = ST_RD_DATA;
            end
            ST_WR_RESP: if (axil.s_bready) state_d = ST_IDLE;
            ST_RD_DATA: if (axil.s_rready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Capture AW/W as they arrive; release both once the pair is consumed
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (wr_go) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = aw_full[11:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = axil.s_wdata;
                wstrb_d  = axil.s_wstrb;
            end
        end
    end

    // Register update and write response code
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        bresp_d   = bresp_q;
        if (wr_go) begin
            bresp_d = 2'b00;
            case (wr_word)
                10'h000: if (wr_strb[0]) ctrl_d = wr_data[1:0];
                10'h001, 10'h003: begin
                    // read-only: accepted, no effect
                end
                10'h002: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                default: bresp_d = UNMAPPED_RESP;
            endcase
        end
    end

    // Read decode; STATUS is snapshotted from the current CTRL and inputs
    always_comb begin
        rd_word = 32'h0;
        rd_resp = 2'b00;
        case (ar_full[11:2])
            10'h000: rd_word = {30'h0, ctrl_q};
            10'h001: rd_word = {29'h0, ctrl_q[1] & ctrl_q[0], tx_busy, rx_sync};
            10'h002: rd_word = scratch_q;
            10'h003: rd_word = ID_VALUE;
            default: rd_resp = UNMAPPED_RESP;
        endcase
    end

    // Read response is loaded only on the AR handshake and then held
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rdata_d = rd_word;
            rresp_d = rd_resp;
        end
    end

    // State flops, all cleared asynchronously
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q   <= ST_IDLE;
            aw_held_q <= 1'b0;
            awaddr_q  <= 10'h0;
            w_held_q  <= 1'b0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            ctrl_q    <= 2'b00;
            scratch_q <= SCRATCH_RST;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_fsic_pl_is_axil_slave.sv
// Directed bench for fsic_pl_is_axil_slave: a transaction-level register model
// checked against the bus every cycle, plus literal read-back expectations.
module tb_fsic_pl_is_axil_slave;

    localparam logic [31:0] ID_VAL = 32'h4649_5331;
    localparam logic [31:0] SC_RST = 32'h0000_0000;
`ifdef FSIC_PL_IS_SLVERR_EN
    localparam logic [1:0] UNM = 2'b10;
`else
    localparam logic [1:0] UNM = 2'b00;
`endif

    logic axi_clk = 1'b0;
    logic axi_reset_n = 1'b0;
    logic tx_busy = 1'b0;
    logic rx_sync = 1'b0;
    logic txen, rxen;

    fsic_pl_is_axil_slave_if #(.ADDR_WIDTH(32)) bus ();

    fsic_pl_is_axil_slave #(
        .ADDR_WIDTH(32), .ID_VALUE(ID_VAL), .SCRATCH_RST(SC_RST)
    ) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .axil(bus),
        .tx_busy(tx_busy), .rx_sync(rx_sync), .txen(txen), .rxen(rxen)
    );

    always #5 axi_clk = ~axi_clk;

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    int b_hs_cyc = 0;
    int ar_hs_cyc = 0;

    always @(posedge axi_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vec++;
        bad++;
        $display("FAIL %s: no handshake within cycle budget (cycle %0d)", name, cyc);
    endtask

    // ---------------- register-level model ----------------
    logic [1:0]  m_ctrl = 2'b00;
    logic [31:0] m_scratch = SC_RST;
    bit          m_aw_held = 0, m_w_held = 0, m_bpend = 0, m_rpend = 0;
    logic [31:0] m_aw_addr = 0, m_w_data = 0;
    logic [3:0]  m_w_strb = 0;
    logic [1:0]  m_bresp = 0, m_rresp = 0;
    logic [31:0] m_rdata = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[11:0] & 12'hFFC)
            12'h000: return {30'h0, m_ctrl};
            12'h004: return {29'h0, m_ctrl == 2'b11, tx_busy, rx_sync};
            12'h008: return m_scratch;
            12'h00C: return ID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return ((a[11:0] & 12'hFFC) <= 12'h00C) ? 2'b00 : UNM;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if ((a[11:0] & 12'hFFC) == 12'h000 && s[0]) m_ctrl = d[1:0];
        if ((a[11:0] & 12'hFFC) == 12'h008) m_scratch = (m_scratch & ~mask) | (d & mask);
        m_bresp = model_resp(a);
    endtask

    // Compare, then advance the model by what the coming edge will do
    always @(negedge axi_clk) begin
        bit idle, aw_now, w_now, pair;
        if (!axi_reset_n) begin
            chk("rst_awready", bus.s_awready, 0);
            chk("rst_wready", bus.s_wready, 0);
            chk("rst_arready", bus.s_arready, 0);
            chk("rst_valids", {bus.s_bvalid, bus.s_rvalid}, 0);
            chk("rst_resps", {bus.s_bresp, bus.s_rresp}, 0);
            chk("rst_rdata", bus.s_rdata, 0);
            chk("rst_en", {txen, rxen}, 0);
            m_ctrl = 0; m_scratch = SC_RST;
            m_aw_held = 0; m_w_held = 0; m_bpend = 0; m_rpend = 0;
        end else begin
            idle   = !m_bpend && !m_rpend;
            aw_now = bus.s_awvalid && idle && !m_aw_held;
            w_now  = bus.s_wvalid && idle && !m_w_held;
            pair   = idle && (m_aw_held || aw_now) && (m_w_held || w_now);
            chk("awready", bus.s_awready, idle && !m_aw_held);
            chk("wready", bus.s_wready, idle && !m_w_held);
            chk("arready", bus.s_arready, idle && !pair);
            chk("bvalid", bus.s_bvalid, m_bpend);
            chk("rvalid", bus.s_rvalid, m_rpend);
            chk("txen_rxen", {txen, rxen}, m_ctrl);
            if (m_bpend) chk("bresp", bus.s_bresp, m_bresp);
            if (m_rpend) begin
                chk("rdata", bus.s_rdata, m_rdata);
                chk("rresp", bus.s_rresp, m_rresp);
            end
            if (m_bpend && bus.s_bready) m_bpend = 0;
            if (m_rpend && bus.s_rready) m_rpend = 0;
            if (pair) begin
                model_write(m_aw_held ? m_aw_addr : bus.s_awaddr,
                            m_w_held ? m_w_data : bus.s_wdata,
                            m_w_held ? m_w_strb : bus.s_wstrb);
                m_aw_held = 0; m_w_held = 0; m_bpend = 1;
            end else begin
                if (aw_now) begin m_aw_held = 1; m_aw_addr = bus.s_awaddr; end
                if (w_now) begin m_w_held = 1; m_w_data = bus.s_wdata; m_w_strb = bus.s_wstrb; end
            end
            if (bus.s_arvalid && idle && !pair) begin
                m_rdata = model_read(bus.s_araddr);
                m_rresp = model_resp(bus.s_araddr);
                m_rpend = 1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, ok = 0;
        int c = 0;
        resp = 2'b11;
        while (!(aw_done && w_done) && c < 60) begin
            bus.s_awvalid = !aw_done && (c >= aw_dly);
            bus.s_awaddr  = addr;
            bus.s_wvalid  = !w_done && (c >= w_dly);
            bus.s_wdata   = data;
            bus.s_wstrb   = strb;
            @(negedge axi_clk);
            aw_hs = bus.s_awvalid && bus.s_awready;
            w_hs  = bus.s_wvalid && bus.s_wready;
            @(posedge axi_clk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            c++;
        end
        bus.s_awvalid = 0;
        bus.s_wvalid  = 0;
        if (!(aw_done && w_done)) begin timeout("wr_accept"); return; end
        chk("bvalid_after_pair", bus.s_bvalid, 1);
        c = 0;
        while (!ok && c < 60) begin
            bus.s_bready = (c >= b_dly);
            @(negedge axi_clk);
            if (bus.s_bvalid && bus.s_bready) begin
                ok = 1; resp = bus.s_bresp; b_hs_cyc = cyc;
            end
            @(posedge axi_clk); #1;
            c++;
        end
        bus.s_bready = 0;
        if (!ok) timeout("wr_bresp");
    endtask

    task automatic rd(input logic [31:0] addr, input int r_dly,
                      output logic [31:0] data, output logic [1:0] resp);
        bit ok = 0;
        int c = 0;
        data = 32'hDEAD_DEAD;
        resp = 2'b11;
        bus.s_arvalid = 1;
        bus.s_araddr  = addr;
        while (!ok && c < 60) begin
            @(negedge axi_clk);
            if (bus.s_arvalid && bus.s_arready) begin ok = 1; ar_hs_cyc = cyc; end
            @(posedge axi_clk); #1;
            c++;
        end
        bus.s_arvalid = 0;
        if (!ok) begin timeout("rd_accept"); return; end
        ok = 0; c = 0;
        while (!ok && c < 60) begin
            bus.s_rready = (c >= r_dly);
            @(negedge axi_clk);
            if (bus.s_rvalid && bus.s_rready) begin
                ok = 1; data = bus.s_rdata; resp = bus.s_rresp;
            end
            @(posedge axi_clk); #1;
            c++;
        end
        bus.s_rready = 0;
        if (!ok) timeout("rd_data");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r, br;
        bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_wvalid = 0; bus.s_wdata = 0;
        bus.s_wstrb = 0; bus.s_bready = 0; bus.s_arvalid = 0; bus.s_araddr = 0;
        bus.s_rready = 0;

        repeat (3) @(posedge axi_clk);
        #1;
        chk("awready_in_reset", bus.s_awready, 0);
        axi_reset_n = 1;
        @(posedge axi_clk); #1;
        chk("awready_after_rst", bus.s_awready, 1);
        chk("arready_after_rst", bus.s_arready, 1);

        // reset values
        rd(32'h7000, 0, d, r); chk("ctrl_rst", d, 0); chk("ctrl_rst_resp", r, 0);
        rd(32'h7008, 0, d, r); chk("scratch_rst", d, SC_RST); chk("scratch_rst_resp", r, 0);
        rd(32'h700C, 0, d, r); chk("id", d, 32'h4649_5331); chk("id_resp", r, 0);
        chk("en_rst", {txen, rxen}, 2'b00);

        // enable sequence
        wr(32'h7000, 32'h1, 4'hF, 0, 0, 0, br); chk("ctrl1_bresp", br, 0);
        chk("rxen_on", {txen, rxen}, 2'b01);
        wr(32'h7000, 32'h3, 4'hF, 0, 0, 0, br);
        rd(32'h7000, 0, d, r); chk("ctrl3", d, 32'h0000_0003);
        chk("txen_on", txen, 1);

        // W three cycles ahead of AW, partial strobes
        wr(32'h7008, 32'hA5A5_5A5A, 4'b0101, 3, 0, 0, br);
        rd(32'h7008, 0, d, r); chk("scratch_w_first", d, 32'h00A5_005A);
        // AW ahead of W
        wr(32'h7008, 32'h1234_5678, 4'b1100, 0, 2, 0, br);
        rd(32'h7008, 0, d, r); chk("scratch_aw_first", d, 32'h1234_005A);

        // STATUS snapshot
        tx_busy = 1; rx_sync = 0;
        rd(32'h7004, 0, d, r); chk("status_busy", d, 32'h6);
        tx_busy = 0; rx_sync = 1;
        rd(32'h7004, 0, d, r); chk("status_sync", d, 32'h5);
        wr(32'h7004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br); chk("ro_bresp", br, 0);

        // CTRL strobe gating and reserved bits
        wr(32'h7000, 32'h0, 4'b1110, 0, 0, 0, br);
        rd(32'h7000, 0, d, r); chk("ctrl_no_strb0", d, 32'h3);
        wr(32'h7000, 32'hFFFF_FFFE, 4'b0001, 0, 0, 0, br);
        rd(32'h7000, 0, d, r); chk("ctrl_reserved", d, 32'h2);
        wr(32'h7000, 32'h3, 4'b0001, 0, 0, 0, br);

        // B backpressure with a read queued behind it
        fork
            wr(32'h7008, 32'hCAFE_F00D, 4'hF, 0, 0, 5, br);
            begin
                repeat (2) @(posedge axi_clk);
                #1;
                rd(32'h7008, 0, d, r);
            end
        join
        chk("bp_bresp", br, 0);
        chk("bp_rdata", d, 32'hCAFE_F00D);
        chk("ar_after_b", ar_hs_cyc > b_hs_cyc, 1);

        // R backpressure
        rd(32'h7008, 5, d, r); chk("rstall_rdata", d, 32'hCAFE_F00D); chk("rstall_rresp", r, 0);

        // write pair and AR in the same cycle
        fork
            wr(32'h7008, 32'h0BAD_BEEF, 4'hF, 0, 0, 0, br);
            rd(32'h7008, 0, d, r);
        join
        chk("simul_rdata", d, 32'h0BAD_BEEF);
        chk("simul_order", ar_hs_cyc > b_hs_cyc, 1);

        // unmapped offset
        wr(32'h7010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br); chk("unm_bresp", br, UNM);
        rd(32'h7010, 0, d, r); chk("unm_rdata", d, 0); chk("unm_rresp", r, UNM);
        rd(32'h7008, 0, d, r); chk("unm_no_side_effect", d, 32'h0BAD_BEEF);

        // reset with only AW held
        bus.s_awvalid = 1; bus.s_awaddr = 32'h7000;
        @(posedge axi_clk); #1;
        bus.s_awvalid = 0;
        @(posedge axi_clk); #1;
        axi_reset_n = 0;
        #1;
        chk("async_rst_en", {txen, rxen}, 2'b00);
        chk("async_rst_rdy", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b000);
        repeat (2) @(posedge axi_clk);
        #1;
        axi_reset_n = 1;
        @(posedge axi_clk); #1;
        wr(32'h7000, 32'h2, 4'b0001, 0, 0, 0, br); chk("post_rst_bresp", br, 0);
        rd(32'h7000, 0, d, r); chk("post_rst_ctrl", d, 32'h2);
        chk("post_rst_en", {txen, rxen}, 2'b10);
        rd(32'h7008, 0, d, r); chk("post_rst_scratch", d, SC_RST);

        repeat (2) @(posedge axi_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
